int_divider: RTL and testbench

Sequential 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the inverse arithmetic companion to the datapath adder: it uses repeated conditional subtraction (restoring, radix-2) instead of addition. It sits beside the ALU in the execute stage. Control stalls the pipeline while the divider reports `busy`.

---
 rtl/rv32m_pkg.sv | 20 ++
 rtl/int_divider_div_step.sv | 26 ++
 rtl/int_divider.sv | 183 ++++++++++++++++++
 tb/tb_int_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared RV32M divide definitions.
// Op encodings, divider FSM states and datapath width.
package rv32m_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/int_divider_div_step.sv
// One restoring radix-2 division iteration.
// Shifts in one dividend bit, trial-subtracts the divisor.
module div_step
  import rv32m_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // Keep the full W+1-bit shifted remainder so large divisors never lose a bit.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {1'b0, dvs_i};
    q_o     = ~trial[W];
    rem_o   = q_o ? trial[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/int_divider.sv
// Sequential RV32M divider: DIV/DIVU/REM/REMU.
// Restoring radix-2, one quotient bit per cycle.
module int_divider
  import rv32m_pkg::*;
#(
  parameter int XLEN = rv32m_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] y
);

  localparam logic [5:0] LAST = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;

  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] y_q, y_d;
  logic            done_q, done_d;

  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div0;
  logic            ovf;
  logic            special;

  logic [XLEN-1:0] step_rem;
  logic            step_q;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  div_step #(
    .W(XLEN)
  ) u_step (
    .rem_i    (rem_q),
    .dvd_msb_i(dvd_q[XLEN-1]),
    .dvs_i    (dvs_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  // Operand decode: magnitudes, signs and the two bypass cases.
  always_comb begin
    signed_op = (op == OP_DIV) || (op == OP_REM);
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & b[XLEN-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    div0      = (b == '0);
    ovf       = signed_op && (a == MIN_NEG) && (b == '1);
    special   = div0 | ovf;
    quo_fix   = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_fix   = rneg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: specials skip straight to FIX.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = special ? FIX : CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: busy from state, done registered from the FIX state.
  always_comb begin
    busy   = (state_q != IDLE);
    done_d = (state_q == FIX);
    done   = done_q;
    y      = y_q;
  end

  // Datapath next values: accept, iterate, then fix up signs.
  always_comb begin
    op_d   = op_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    y_d    = y_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          if (div0) begin
            dvd_d  = '1;
            dvs_d  = b;
            rem_d  = a;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else if (ovf) begin
            dvd_d  = MIN_NEG;
            dvs_d  = b;
            rem_d  = '0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else begin
            dvd_d  = a_mag;
            dvs_d  = b_mag;
            rem_d  = '0;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[XLEN-2:0], step_q};
        cnt_d = cnt_q + 6'd1;
      end
      FIX: begin
        y_d = op_q[1] ? rem_fix : quo_fix;
      end
      default: begin
        op_d = op_q;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider.
// Vector table plus hand sequences for re-issue and reset.
module tb_int_divider;
  import rv32m_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          fix;
  } vec_t;

  vec_t tv[17];

  int_divider dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_result(input string name);
    if (sb.size() == 0) begin
      chk({name, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      chk({name, "/y"}, y, sb.pop_front());
    end
  endtask

  task automatic wait_done(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic apply(input string name, input logic [1:0] o,
                       input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] exp, input int fix);
    int n;
    bit ok;
    logic [31:0] held;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, "/busy"}, 32'(busy), 32'd1);
    wait_done(100, n, ok);
    chk({name, "/timeout"}, 32'(ok), 32'd1);
    chk({name, "/fix_edge"}, 32'(n), 32'(fix));
    chk({name, "/busy_at_done"}, 32'(busy), 32'd0);
    check_result(name);
    held = y;
    @(posedge clk);
    #1;
    chk({name, "/pulse"}, 32'(done), 32'd0);
    chk({name, "/held"}, y, held);
  endtask

  initial begin
    int n;
    int extra;
    bit ok;

    tv[0]  = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 33};
    tv[1]  = '{OP_REMU, 32'd100, 32'd7, 32'd2, 33};
    tv[2]  = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    tv[3]  = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    tv[4]  = '{OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    tv[5]  = '{OP_REMU, 32'd5, 32'd0, 32'd5, 1};
    tv[6]  = '{OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    tv[7]  = '{OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1};
    tv[8]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    tv[9]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
    tv[10] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
    tv[11] = '{OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33};
    tv[12] = '{OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33};
    tv[13] = '{OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33};
    tv[14] = '{OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33};
    tv[15] = '{OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 33};
    tv[16] = '{OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    #12;
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/done", 32'(done), 32'd0);
    chk("reset/y", y, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b,
            tv[i].y, tv[i].fix);
    end

    // Re-issue while busy: the extra starts must be ignored.
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    sb.push_back(32'd14);
    @(posedge clk);
    #1;
    n  = 0;
    ok = 1'b0;
    while (n < 100 && !ok) begin
      if (n == 5 || n == 20) begin
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd1000;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
      if (done) ok = 1'b1;
    end
    start = 1'b0;
    chk("reissue/timeout", 32'(ok), 32'd1);
    chk("reissue/fix_edge", 32'(n), 32'd33);
    check_result("reissue");
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk("reissue/extra_done", 32'(extra), 32'd0);
    chk("reissue/idle", 32'(busy), 32'd0);
    chk("reissue/y_held", y, 32'd14);

    // Reset mid-operation clears everything immediately.
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst/busy", 32'(busy), 32'd0);
    chk("midrst/done", 32'(done), 32'd0);
    chk("midrst/y", y, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("after_rst", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    chk("sb/drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
